// File: rtl/tipi_rpi_link_ctrl_pkg.sv
// Shared definitions for the TIPI RPi serial register link.
// Register selects and controller state encodings.
package tipi_rpi_link_ctrl_pkg;

  localparam logic [1:0] REGSEL_RD = 2'b00;
  localparam logic [1:0] REGSEL_RC = 2'b01;
  localparam logic [1:0] REGSEL_TD = 2'b10;
  localparam logic [1:0] REGSEL_TC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } link_state_e;

endpackage

// File: rtl/tipi_sync_edge.sv
// Multi-flop synchroniser for one async RPi strobe.
// Emits a registered 1-clk pulse on each rising edge.
import tipi_rpi_link_ctrl_pkg::*;

module tipi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic mask_i,
  input  logic d_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rise_q;
  logic                   rise_d;

  // Edge taken between the last two stages; suppressed while masked.
  assign rise_d = sync_q[SYNC_STAGES-2]
                & ~sync_q[SYNC_STAGES-1]
                & ~mask_i;

  // Shift chain and rise pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      rise_q <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/tipi_rpi_link_ctrl.sv
// Board-clock controller for the RPi serial register link.
// Receives RD/RC frames and serialises TD/TC snapshots.
import tipi_rpi_link_ctrl_pkg::*;

module tipi_rpi_link_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rpi_sclk,
  input  logic             rpi_sle,
  input  logic [1:0]       rpi_regsel,
  input  logic             rpi_sdata_in,
  output logic             rpi_sdata_out,
  input  logic [WIDTH-1:0] td_in,
  input  logic [WIDTH-1:0] tc_in,
  output logic [WIDTH-1:0] rd_out,
  output logic [WIDTH-1:0] rc_out,
  output logic             rd_update,
  output logic             rc_update,
  output logic             frame_err,
  input  logic             err_clr
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int MW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_OVR  = CW'(WIDTH + 1);

  logic [MW-1:0]                mask_cnt_q;
  logic                         mask;
  logic                         sclk_rise;
  logic                         sle_rise;
  logic [SYNC_STAGES-1:0][2:0]  dsync_q;
  logic [1:0]                   regsel_s;
  logic                         sdata_s;

  link_state_e                  state_q;
  logic [1:0]                   cur_sel_q;
  logic [CW-1:0]                bit_cnt_q;
  logic [CW-1:0]                bit_cnt_d;
  logic [0:WIDTH-1]             in_sr_q;
  logic [0:WIDTH-1]             in_sr_d;
  logic [0:WIDTH-1]             out_sr_q;
  logic [0:WIDTH-1]             out_sr_d;
  logic [WIDTH-1:0]             rd_q;
  logic [WIDTH-1:0]             rc_q;
  logic                         rd_upd_q;
  logic                         rc_upd_q;
  logic                         err_q;
  logic                         err_set;
  logic                         sel_bad;
  logic                         cnt_bad;

  // Blank edge detection until the synchronisers hold post-reset levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_cnt_q <= MW'(SYNC_STAGES + 1);
    end else if (mask_cnt_q != '0) begin
      mask_cnt_q <= mask_cnt_q - 1'b1;
    end
  end

  assign mask = (mask_cnt_q != '0);

  tipi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sclk (
    .clk   (clk),
    .rst   (rst),
    .mask_i(mask),
    .d_i   (rpi_sclk),
    .rise_o(sclk_rise)
  );

  tipi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sle (
    .clk   (clk),
    .rst   (rst),
    .mask_i(mask),
    .d_i   (rpi_sle),
    .rise_o(sle_rise)
  );

  // Same-depth synchroniser keeps regsel/sdata aligned with the pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      dsync_q <= '0;
    end else begin
      dsync_q <= {dsync_q[SYNC_STAGES-2:0],
                  {rpi_regsel, rpi_sdata_in}};
    end
  end

  assign regsel_s = dsync_q[SYNC_STAGES-1][2:1];
  assign sdata_s  = dsync_q[SYNC_STAGES-1][0];

  assign in_sr_d  = {in_sr_q[1:WIDTH-1], sdata_s};
  assign out_sr_d = {out_sr_q[1:WIDTH-1], 1'b0};
  assign bit_cnt_d = (bit_cnt_q == CNT_OVR) ? CNT_OVR
                   : bit_cnt_q + 1'b1;

  assign sel_bad = (state_q == ST_SHIFT) && (regsel_s != cur_sel_q);
  assign cnt_bad = (state_q == ST_COMMIT) && !cur_sel_q[1]
                && (bit_cnt_q != CNT_FULL);
  assign err_set = sel_bad | cnt_bad;

  // Frame FSM with shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_sel_q <= REGSEL_RD;
      bit_cnt_q <= '0;
      in_sr_q   <= '0;
      out_sr_q  <= '0;
      rd_q      <= '0;
      rc_q      <= '0;
      rd_upd_q  <= 1'b0;
      rc_upd_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rd_upd_q <= 1'b0;
      rc_upd_q <= 1'b0;
      err_q    <= err_set | (err_q & ~err_clr);
      unique case (state_q)
        ST_IDLE: begin
          if (sclk_rise) begin
            in_sr_q   <= in_sr_d;
            out_sr_q  <= out_sr_d;
            bit_cnt_q <= CW'(1);
            cur_sel_q <= regsel_s;
            state_q   <= ST_SHIFT;
          end
          if (sle_rise) begin
            cur_sel_q <= regsel_s;
            state_q   <= ST_COMMIT;
          end
        end
        ST_SHIFT: begin
          if (sel_bad) begin
            bit_cnt_q <= '0;
            state_q   <= ST_IDLE;
          end else begin
            if (sclk_rise) begin
              in_sr_q   <= in_sr_d;
              out_sr_q  <= out_sr_d;
              bit_cnt_q <= bit_cnt_d;
            end
            if (sle_rise) begin
              state_q <= ST_COMMIT;
            end
          end
        end
        ST_COMMIT: begin
          bit_cnt_q <= '0;
          state_q   <= ST_IDLE;
          unique case (cur_sel_q)
            REGSEL_RD: if (!cnt_bad) begin
              rd_q     <= in_sr_q;
              rd_upd_q <= 1'b1;
            end
            REGSEL_RC: if (!cnt_bad) begin
              rc_q     <= in_sr_q;
              rc_upd_q <= 1'b1;
            end
            REGSEL_TD: out_sr_q <= td_in;
            REGSEL_TC: out_sr_q <= tc_in;
            default:   out_sr_q <= out_sr_q;
          endcase
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rpi_sdata_out = out_sr_q[0];
  assign rd_out        = rd_q;
  assign rc_out        = rc_q;
  assign rd_update     = rd_upd_q;
  assign rc_update     = rc_upd_q;
  assign frame_err     = err_q;

endmodule

// File: tb/tb_tipi_rpi_link_ctrl.sv
// Bench for the TIPI RPi link controller.
// Directed frames; register updates checked via a scoreboard queue.
module tb_tipi_rpi_link_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rpi_sclk = 1'b0;
  logic       rpi_sle = 1'b0;
  logic [1:0] rpi_regsel = 2'b00;
  logic       rpi_sdata_in = 1'b0;
  logic       rpi_sdata_out;
  logic [7:0] td_in = 8'h3C;
  logic [7:0] tc_in = 8'h99;
  logic [7:0] rd_out;
  logic [7:0] rc_out;
  logic       rd_update;
  logic       rc_update;
  logic       frame_err;
  logic       err_clr = 1'b0;

  typedef struct packed {
    logic       is_rc;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  tipi_rpi_link_ctrl #(
    .SYNC_STAGES(2),
    .WIDTH      (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rpi_sclk     (rpi_sclk),
    .rpi_sle      (rpi_sle),
    .rpi_regsel   (rpi_regsel),
    .rpi_sdata_in (rpi_sdata_in),
    .rpi_sdata_out(rpi_sdata_out),
    .td_in        (td_in),
    .tc_in        (tc_in),
    .rd_out       (rd_out),
    .rc_out       (rc_out),
    .rd_update    (rd_update),
    .rc_update    (rc_update),
    .frame_err    (frame_err),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic sclk_bit(input logic b);
    rpi_sdata_in = b;
    wclk(4);
    rpi_sclk = 1'b1;
    wclk(4);
    rpi_sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) sclk_bit(v[i]);
  endtask

  task automatic sle_pulse();
    wclk(4);
    rpi_sle = 1'b1;
    wclk(4);
    rpi_sle = 1'b0;
    wclk(6);
  endtask

  // Scoreboard monitor: every update pulse must match the queue head.
  always @(negedge clk) begin
    if (rd_update || rc_update) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: rd_upd=%b rc_upd=%b want none",
                 rd_update, rc_update);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rd_update === rc_update || rc_update !== e.is_rc) begin
          failures++;
          $display("FAIL sb_target: rd_upd=%b rc_upd=%b want is_rc=%b",
                   rd_update, rc_update, e.is_rc);
        end else if ((e.is_rc ? rc_out : rd_out) !== e.val) begin
          failures++;
          $display("FAIL sb_value: got %h want %h",
                   e.is_rc ? rc_out : rd_out, e.val);
        end
      end
    end
  end

  initial begin
    logic [7:0] td_pat;
    int         waited;

    wclk(3);
    rst = 1'b0;
    wclk(6);
    chk("rst_rd", rd_out, 8'h00);
    chk("rst_rc", rc_out, 8'h00);
    chk("rst_sdo", {7'd0, rpi_sdata_out}, 8'h00);
    chk("rst_err", {7'd0, frame_err}, 8'h00);

    // 1: RD write 0xA5
    rpi_regsel = 2'b00;
    exp_q.push_back('{is_rc: 1'b0, val: 8'hA5});
    send_byte(8'hA5);
    sle_pulse();
    chk("t1_rd", rd_out, 8'hA5);
    chk("t1_rc", rc_out, 8'h00);
    chk("t1_err", {7'd0, frame_err}, 8'h00);

    // 2: TD read of 0x3C
    rpi_regsel = 2'b10;
    td_pat = 8'h3C;
    sle_pulse();
    for (int i = 7; i >= 0; i--) begin
      chk($sformatf("t2_bit%0d", 7 - i),
          {7'd0, rpi_sdata_out}, {7'd0, td_pat[i]});
      sclk_bit(1'b0);
    end
    wclk(4);
    chk("t2_tail", {7'd0, rpi_sdata_out}, 8'h00);
    sle_pulse();
    chk("t2_err", {7'd0, frame_err}, 8'h00);

    // 3: short RC frame
    rpi_regsel = 2'b01;
    for (int i = 0; i < 7; i++) sclk_bit(1'b1);
    sle_pulse();
    chk("t3_rc", rc_out, 8'h00);
    chk("t3_err", {7'd0, frame_err}, 8'h01);
    err_clr = 1'b1;
    wclk(1);
    err_clr = 1'b0;
    wclk(1);
    chk("t3_clr", {7'd0, frame_err}, 8'h00);

    // 4: regsel change mid-frame, then good RC frame
    rpi_regsel = 2'b00;
    sclk_bit(1'b1);
    sclk_bit(1'b0);
    sclk_bit(1'b1);
    wclk(2);
    rpi_regsel = 2'b01;
    wclk(6);
    chk("t4_err", {7'd0, frame_err}, 8'h01);
    chk("t4_rd", rd_out, 8'hA5);
    exp_q.push_back('{is_rc: 1'b1, val: 8'h5A});
    send_byte(8'h5A);
    sle_pulse();
    chk("t4_rc", rc_out, 8'h5A);
    chk("t4_sticky", {7'd0, frame_err}, 8'h01);
    err_clr = 1'b1;
    wclk(1);
    err_clr = 1'b0;

    // 5: sclk and sle rise together on the last bit
    rpi_regsel = 2'b00;
    exp_q.push_back('{is_rc: 1'b0, val: 8'hC3});
    for (int i = 7; i >= 1; i--) sclk_bit(8'hC3 >> i);
    rpi_sdata_in = 1'b1;
    wclk(4);
    rpi_sclk = 1'b1;
    rpi_sle  = 1'b1;
    wclk(4);
    rpi_sclk = 1'b0;
    rpi_sle  = 1'b0;
    wclk(6);
    chk("t5_rd", rd_out, 8'hC3);
    chk("t5_err", {7'd0, frame_err}, 8'h00);

    // 6: reset mid-frame with pins high at release
    for (int i = 0; i < 3; i++) sclk_bit(1'b1);
    rpi_sdata_in = 1'b1;
    wclk(4);
    rpi_sclk = 1'b1;
    wclk(2);
    rpi_sle = 1'b1;
    rst = 1'b1;
    wclk(2);
    rst = 1'b0;
    wclk(10);
    chk("t6_rd", rd_out, 8'h00);
    chk("t6_err", {7'd0, frame_err}, 8'h00);
    chk("t6_sdo", {7'd0, rpi_sdata_out}, 8'h00);
    rpi_sclk = 1'b0;
    rpi_sle  = 1'b0;
    wclk(6);

    // Link still works after the reset
    exp_q.push_back('{is_rc: 1'b0, val: 8'h81});
    send_byte(8'h81);
    sle_pulse();
    chk("t6_post", rd_out, 8'h81);

    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      wclk(1);
      waited++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: pending %0d want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
